// File: rtl/gb_frame_sequencer_if.sv
// Frame sequencer bus: enable/DIV source in, timing strobes and step index out.
interface gb_frame_sequencer_if;
  logic       apu_enable;
  logic       div_bit;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [2:0] step;
  logic       length_next_clocks;

  // Controller side: drives enable and the DIV source, consumes strobes.
  modport master (
    output apu_enable,
    output div_bit,
    input  clk_length_ctr,
    input  clk_sweep,
    input  clk_vol_env,
    input  step,
    input  length_next_clocks
  );

  // Sequencer side.
  modport slave (
    input  apu_enable,
    input  div_bit,
    output clk_length_ctr,
    output clk_sweep,
    output clk_vol_env,
    output step,
    output length_next_clocks
  );
endinterface

// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: divides the 512 Hz DIV-APU event into the length
// (256 Hz), sweep (128 Hz) and envelope (64 Hz) one-cycle strobes.
// Events come either from falling edges of an external DIV bit or from an
// internal free-running divider, selected by EXT_DIV.
module gb_frame_sequencer #(
  parameter bit          EXT_DIV    = 1'b1,
  parameter int unsigned DIV_CYCLES = 8192
) (
  input logic                 clk,
  input logic                 rst_n,
  gb_frame_sequencer_if.slave bus
);

  localparam logic [15:0] CNT_LAST = 16'(DIV_CYCLES - 1);

  logic        div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic        length_q, length_d;
  logic        sweep_q, sweep_d;
  logic        env_q, env_d;

  logic        ext_event;
  logic        int_event;
  logic        seq_event;

  // Event detection for both sources; disable always wins over an event.
  always_comb begin
    ext_event = div_q & ~bus.div_bit & bus.apu_enable;
    int_event = bus.apu_enable & (cnt_q == CNT_LAST);
    seq_event = EXT_DIV ? ext_event : int_event;
  end

  // Next-state for the DIV delay flop, the internal divider and the step index.
  always_comb begin
    div_d  = bus.div_bit;
    cnt_d  = 16'd0;
    step_d = step_q;
    if (!EXT_DIV && bus.apu_enable && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (!bus.apu_enable) begin
      step_d = 3'd0;
    end else if (seq_event) begin
      step_d = step_q + 3'd1;
    end
  end

  // Strobe decode from the step being executed on this event.
  always_comb begin
    length_d = 1'b0;
    sweep_d  = 1'b0;
    env_d    = 1'b0;
    if (seq_event) begin
      length_d = ~step_q[0];
      sweep_d  = (step_q == 3'd2) || (step_q == 3'd6);
      env_d    = (step_q == 3'd7);
    end
  end

  // State registers; reset clears any in-flight strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 1'b0;
      cnt_q    <= 16'd0;
      step_q   <= 3'd0;
      length_q <= 1'b0;
      sweep_q  <= 1'b0;
      env_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      length_q <= length_d;
      sweep_q  <= sweep_d;
      env_q    <= env_d;
    end
  end

  // Output mapping; the length-enable quirk looks at whether the next step is even.
  always_comb begin
    bus.clk_length_ctr     = length_q;
    bus.clk_sweep          = sweep_q;
    bus.clk_vol_env        = env_q;
    bus.step               = step_q;
    bus.length_next_clocks = ~step_q[0];
  end

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Directed self-checking bench for gb_frame_sequencer (external and internal DIV modes).
module tb_gb_frame_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gb_frame_sequencer_if ext_if ();
  gb_frame_sequencer_if int_if ();

  gb_frame_sequencer #(.EXT_DIV(1'b1), .DIV_CYCLES(8192)) u_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ext_if.slave)
  );

  gb_frame_sequencer #(.EXT_DIV(1'b0), .DIV_CYCLES(4)) u_int (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (int_if.slave)
  );

  // Expected strobes/step after edges 1..8 starting from step 0.
  logic       exp_len_tab  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       exp_sw_tab   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       exp_env_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] exp_step_tab [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  int len_cnt;
  int sw_cnt;
  int env_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One falling edge of div_bit, then 3 quiet cycles (edges 4 cycles apart).
  task automatic do_edge(input logic e_len, input logic e_sw, input logic e_env,
                         input logic [2:0] e_step, input string name);
    ext_if.div_bit = 1'b0;
    tick();
    checks++;
    if ({ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env} !== {e_len, e_sw, e_env}) begin
      failures++;
      $display("[TB] FAIL %s strobes: got len/sw/env=%b%b%b expected %b%b%b", name,
               ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env, e_len, e_sw, e_env);
    end
    checks++;
    if (ext_if.step !== e_step) begin
      failures++;
      $display("[TB] FAIL %s step: got %0d expected %0d", name, ext_if.step, e_step);
    end
    checks++;
    if (ext_if.length_next_clocks !== ~e_step[0]) begin
      failures++;
      $display("[TB] FAIL %s length_next_clocks: got %b expected %b", name,
               ext_if.length_next_clocks, ~e_step[0]);
    end
    if (ext_if.clk_length_ctr === 1'b1) len_cnt++;
    if (ext_if.clk_sweep === 1'b1)      sw_cnt++;
    if (ext_if.clk_vol_env === 1'b1)    env_cnt++;
    ext_if.div_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL %s quiet cycle %0d: got len/sw/env=%b%b%b expected 000", name, i,
                 ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ext_if.apu_enable = 1'b0;
    ext_if.div_bit    = 1'b0;
    int_if.apu_enable = 1'b0;
    int_if.div_bit    = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env, ext_if.step,
         ext_if.length_next_clocks} !== 7'b000_000_1) begin
      failures++;
      $display("[TB] FAIL reset_ext: got len/sw/env=%b%b%b step=%0d lnc=%b expected 000 step=0 lnc=1",
               ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env, ext_if.step,
               ext_if.length_next_clocks);
    end
    checks++;
    if ({int_if.clk_length_ctr, int_if.clk_sweep, int_if.clk_vol_env, int_if.step,
         int_if.length_next_clocks} !== 7'b000_000_1) begin
      failures++;
      $display("[TB] FAIL reset_int: got len/sw/env=%b%b%b step=%0d lnc=%b expected 000 step=0 lnc=1",
               int_if.clk_length_ctr, int_if.clk_sweep, int_if.clk_vol_env, int_if.step,
               int_if.length_next_clocks);
    end
  endtask

  task automatic test_full_cycle();
    ext_if.apu_enable = 1'b1;
    ext_if.div_bit    = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      do_edge(exp_len_tab[i], exp_sw_tab[i], exp_env_tab[i], exp_step_tab[i],
              $sformatf("full_edge%0d", i + 1));
    end
  endtask

  task automatic test_wrap();
    len_cnt = 0;
    sw_cnt  = 0;
    env_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      do_edge(exp_len_tab[i % 8], exp_sw_tab[i % 8], exp_env_tab[i % 8], exp_step_tab[i % 8],
              $sformatf("wrap_edge%0d", i + 1));
    end
    checks++;
    if (len_cnt != 8 || sw_cnt != 4 || env_cnt != 2) begin
      failures++;
      $display("[TB] FAIL wrap_counts: got len=%0d sw=%0d env=%0d expected 8 4 2",
               len_cnt, sw_cnt, env_cnt);
    end
  endtask

  task automatic test_disable();
    for (int i = 0; i < 5; i++) begin
      do_edge(exp_len_tab[i], exp_sw_tab[i], exp_env_tab[i], exp_step_tab[i],
              $sformatf("dis_pre_edge%0d", i + 1));
    end
    // Falling edge in the same cycle enable drops: must not strobe.
    ext_if.apu_enable = 1'b0;
    ext_if.div_bit    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env} !== 3'b000 ||
          ext_if.step !== 3'd0) begin
        failures++;
        $display("[TB] FAIL disabled_cycle%0d: got len/sw/env=%b%b%b step=%0d expected 000 step=0", i,
                 ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.clk_vol_env, ext_if.step);
      end
      ext_if.div_bit = ~ext_if.div_bit;
    end
    ext_if.apu_enable = 1'b1;
    ext_if.div_bit    = 1'b1;
    repeat (2) tick();
    do_edge(1'b1, 1'b0, 1'b0, 3'd1, "reenable_edge");
  endtask

  task automatic test_internal();
    logic [2:0] prev_step;
    int         first_len;
    int         step_changes;
    int         ilen;
    int         ienv;
    first_len    = -1;
    step_changes = 0;
    ilen         = 0;
    ienv         = 0;
    prev_step    = int_if.step;
    int_if.apu_enable = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (int_if.step !== prev_step) step_changes++;
      prev_step = int_if.step;
      if (int_if.clk_length_ctr === 1'b1) begin
        ilen++;
        if (first_len < 0) first_len = c;
      end
      if (int_if.clk_vol_env === 1'b1) ienv++;
    end
    checks++;
    if (first_len != 4) begin
      failures++;
      $display("[TB] FAIL int_first_strobe: got cycle %0d expected 4", first_len);
    end
    checks++;
    if (step_changes != 16) begin
      failures++;
      $display("[TB] FAIL int_events: got %0d expected 16", step_changes);
    end
    checks++;
    if (ienv != 2 || ilen != 8) begin
      failures++;
      $display("[TB] FAIL int_strobe_counts: got env=%0d len=%0d expected env=2 len=8", ienv, ilen);
    end
    int_if.apu_enable = 1'b0;
    tick();
    checks++;
    if (int_if.step !== 3'd0) begin
      failures++;
      $display("[TB] FAIL int_disable_step: got %0d expected 0", int_if.step);
    end
  endtask

  task automatic test_async_reset();
    // Current step is 1: one edge with no strobe, next edge (step 2) strobes length.
    do_edge(1'b0, 1'b0, 1'b0, 3'd2, "ar_pre_edge");
    ext_if.div_bit = 1'b0;
    tick();
    checks++;
    if (ext_if.clk_length_ctr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ar_strobe_high: got %b expected 1", ext_if.clk_length_ctr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ext_if.clk_length_ctr !== 1'b0 || ext_if.clk_sweep !== 1'b0 || ext_if.step !== 3'd0 ||
        ext_if.length_next_clocks !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ar_cleared: got len=%b sw=%b step=%0d lnc=%b expected 0 0 0 1",
               ext_if.clk_length_ctr, ext_if.clk_sweep, ext_if.step, ext_if.length_next_clocks);
    end
    ext_if.div_bit = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    len_cnt  = 0;
    sw_cnt   = 0;
    env_cnt  = 0;
    test_reset();
    test_full_cycle();
    test_wrap();
    test_disable();
    test_internal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
